// File: rtl/req_gnt_rr_sched.sv
// -----------------------------------------------------------------------------
// req_gnt_rr_sched
// Round-robin scheduler that shares one resource among N_REQ tagged requesters.
// Each requester posts a request with a rising edge on req[i] and an ID tag on
// its slice of req_id. One request per requester is held pending. Grants are
// issued one at a time as single-cycle pulses that carry the winner index
// (one-hot) and the captured ID. After each grant the resource is held busy for
// BUSY_CYC cycles before another grant can be issued.
//
// Ports
//   clk      in   1            rising-edge clock
//   rst_n    in   1            asynchronous active-low reset
//   req      in   N_REQ        request lines; a new request is a rising edge
//   req_id   in   N_REQ*ID_W   ID of requester i on bits [i*ID_W +: ID_W]
//   gnt      out  1            one-cycle grant pulse
//   gnt_vec  out  N_REQ        one-hot winner while gnt=1, else 0
//   gnt_id   out  ID_W         captured ID of the winner; held between grants
//   pend     out  N_REQ        pending-request flags
//   drop     out  1            one-cycle pulse: request lost, slot already pending
//   busy     out  1            high while in GRANT or BUSY
// -----------------------------------------------------------------------------
module req_gnt_rr_sched #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int BUSY_CYC = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    output logic                    gnt,
    output logic [N_REQ-1:0]        gnt_vec,
    output logic [ID_W-1:0]         gnt_id,
    output logic [N_REQ-1:0]        pend,
    output logic                    drop,
    output logic                    busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_CYC + 1);
    localparam logic [N_REQ-1:0] ONE_VEC  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Registered state
    state_t                       state_r;
    logic [CNT_W-1:0]             cnt_r;
    logic [PTR_W-1:0]             rr_ptr_r;
    logic [N_REQ-1:0]             req_q_r;
    logic [N_REQ-1:0]             pend_r;
    logic [N_REQ-1:0][ID_W-1:0]   id_q_r;
    logic                         gnt_r;
    logic [N_REQ-1:0]             gnt_vec_r;
    logic [ID_W-1:0]              gnt_id_r;
    logic                         drop_r;
    logic                         busy_r;

    // Next-state values
    state_t                       state_s;
    logic [CNT_W-1:0]             cnt_s;
    logic [PTR_W-1:0]             rr_ptr_s;
    logic [N_REQ-1:0]             pend_s;
    logic [N_REQ-1:0][ID_W-1:0]   id_q_s;
    logic                         gnt_s;
    logic [N_REQ-1:0]             gnt_vec_s;
    logic [ID_W-1:0]              gnt_id_s;
    logic                         drop_s;
    logic                         busy_s;

    // Arbitration / edge detect
    logic [N_REQ-1:0]             rise_s;
    logic [PTR_W-1:0]             win_s;
    logic                         win_vld_s;
    logic                         grant_s;

    assign rise_s = req & ~req_q_r;

    // Round-robin winner: first pending slot at or after rr_ptr, wrapping.
    // The scan runs from the farthest offset down to offset 0 so that the last
    // hit assigned is the nearest one, which avoids an early loop exit.
    always_comb begin
        win_s     = '0;
        win_vld_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [PTR_W:0]   sum_v;
            logic [PTR_W-1:0] idx_v;
            sum_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
            idx_v = (sum_v >= N_WIDE) ? PTR_W'(sum_v - N_WIDE) : PTR_W'(sum_v);
            if (pend_r[idx_v]) begin
                win_s     = idx_v;
                win_vld_s = 1'b1;
            end else begin
                win_s     = win_s;
                win_vld_s = win_vld_s;
            end
        end
    end

    // FSM next state, grant outputs, busy counter and round-robin pointer
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rr_ptr_s  = rr_ptr_r;
        gnt_s     = 1'b0;
        gnt_vec_s = '0;
        gnt_id_s  = gnt_id_r;
        grant_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    grant_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Counter was loaded on entry and holds here; BUSY counts it down.
                state_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_r <= CNT_ONE) begin
                    if (win_vld_s) begin
                        grant_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase

        if (grant_s) begin
            state_s   = ST_GRANT;
            gnt_s     = 1'b1;
            gnt_vec_s = ONE_VEC << win_s;
            gnt_id_s  = id_q_r[win_s];
            cnt_s     = CNT_LOAD;
            rr_ptr_s  = (win_s == LAST_IDX) ? '0 : win_s + PTR_W'(1);
        end else begin
            rr_ptr_s  = rr_ptr_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // Pending flags, ID capture and drop detection
    always_comb begin
        pend_s = pend_r;
        id_q_s = id_q_r;
        drop_s = 1'b0;

        // The grant retires the old request first so a capture on the same
        // slot in the same cycle is accepted as a fresh request.
        if (grant_s) begin
            pend_s[win_s] = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (rise_s[i]) begin
                if (!pend_r[i] || (grant_s && (win_s == PTR_W'(i)))) begin
                    pend_s[i] = 1'b1;
                    id_q_s[i] = req_id[i*ID_W +: ID_W];
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                drop_s = drop_s;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            rr_ptr_r  <= '0;
            req_q_r   <= '0;
            pend_r    <= '0;
            id_q_r    <= '0;
            gnt_r     <= 1'b0;
            gnt_vec_r <= '0;
            gnt_id_r  <= '0;
            drop_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rr_ptr_r  <= rr_ptr_s;
            req_q_r   <= req;
            pend_r    <= pend_s;
            id_q_r    <= id_q_s;
            gnt_r     <= gnt_s;
            gnt_vec_r <= gnt_vec_s;
            gnt_id_r  <= gnt_id_s;
            drop_r    <= drop_s;
            busy_r    <= busy_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_vec = gnt_vec_r;
    assign gnt_id  = gnt_id_r;
    assign pend    = pend_r;
    assign drop    = drop_r;
    assign busy    = busy_r;

endmodule
